// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin sharing of one UartTx among NUM_REQ byte
// requesters. Each granted byte is framed (start, data LSB-first, stop) and
// handed over through the tx_start/tx_busy/tx_done handshake, one frame at a time.
// Optional watchdog: define UART_ARB_WDOG_EN to build the START/WAIT_DONE
// timeout (WDOG_CYCLES) and the sticky wdog_err flag.
module uart_tx_arbiter #(
  parameter int unsigned NUM_REQ     = 4,
  parameter int unsigned DATA_BITS   = 8,
  parameter int unsigned FRAME_BITS  = DATA_BITS + 2,
  parameter int unsigned WDOG_CYCLES = 1_000_000
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_REQ-1:0]           req_valid,
  input  logic [NUM_REQ*DATA_BITS-1:0] req_data,
  output logic [NUM_REQ-1:0]           req_ready,
  output logic [FRAME_BITS-1:0]        frame_data,
  output logic                         tx_start,
  input  logic                         tx_busy,
  input  logic                         tx_done,
  output logic [$clog2(NUM_REQ)-1:0]   grant_id,
  output logic                         arb_busy,
  output logic                         done_pulse,
  output logic                         wdog_err
);

  localparam int unsigned IDW = $clog2(NUM_REQ);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    START     = 2'd1,
    WAIT_DONE = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [IDW-1:0]        rr_q, rr_d;
  logic [IDW-1:0]        grant_q, grant_d;
  logic [FRAME_BITS-1:0] frame_q, frame_d;
  logic                  txs_q, txs_d;
  logic                  done_q, done_d;

  logic [IDW-1:0]        scan_idx;
  logic [IDW-1:0]        win;
  logic                  found;
  logic                  wdog_hit;
  logic [DATA_BITS-1:0]  req_bytes [NUM_REQ];
  logic [DATA_BITS-1:0]  win_data;
  logic [FRAME_BITS-1:0] win_frame;

  // Unpack the flat data bus and build the frame for the current winner
  for (genvar g = 0; g < NUM_REQ; g++) begin : g_bytes
    assign req_bytes[g] = req_data[g*DATA_BITS +: DATA_BITS];
  end

  assign win_data = req_bytes[win];

  // frame_data[FRAME_BITS-1] is shifted out first, so data[0] sits just below it
  assign win_frame[FRAME_BITS-1] = 1'b0;
  assign win_frame[0]            = 1'b1;
  for (genvar g = 0; g < DATA_BITS; g++) begin : g_frame
    assign win_frame[FRAME_BITS-2-g] = win_data[g];
  end

  // Round-robin search: first valid requester at or above rr_q, wrapping
  always_comb begin
    found    = 1'b0;
    win      = '0;
    scan_idx = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      scan_idx = IDW'((32'(rr_q) + k) % NUM_REQ);
      if (!found && req_valid[scan_idx]) begin
        found = 1'b1;
        win   = scan_idx;
      end
    end
  end

  // One-hot accept, only while idle and out of reset
  always_comb begin
    req_ready = '0;
    if (rst && (state_q == IDLE) && found) begin
      req_ready[win] = 1'b1;
    end
  end

  // Next-state and handshake sequencing
  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    grant_d = grant_q;
    frame_d = frame_q;
    txs_d   = txs_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (found) begin
          frame_d = win_frame;
          grant_d = win;
          rr_d    = IDW'((32'(win) + 32'd1) % NUM_REQ);
          // hold off tx_start while UartTx is still finishing an earlier frame
          txs_d   = !tx_busy;
          state_d = START;
        end
      end
      START: begin
        if (!txs_q) begin
          if (!tx_busy) txs_d = 1'b1;
        end else if (tx_busy) begin
          txs_d = 1'b0;
          if (tx_done) begin
            done_d  = 1'b1;
            state_d = IDLE;
          end else begin
            state_d = WAIT_DONE;
          end
        end
      end
      WAIT_DONE: begin
        if (tx_done) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (wdog_hit) begin
      state_d = IDLE;
      txs_d   = 1'b0;
      done_d  = 1'b0;
    end
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      rr_q    <= '0;
      grant_q <= '0;
      frame_q <= '1;
      txs_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      grant_q <= grant_d;
      frame_q <= frame_d;
      txs_q   <= txs_d;
      done_q  <= done_d;
    end
  end

`ifdef UART_ARB_WDOG_EN
  localparam int unsigned WCW = $clog2(WDOG_CYCLES + 1);

  logic [WCW-1:0] wcnt_q, wcnt_d;
  logic           wdog_q, wdog_d;

  assign wdog_hit = (state_q != IDLE) && (wcnt_q == WCW'(WDOG_CYCLES - 1));

  // Cycles spent outside IDLE; the error flag is sticky until reset
  always_comb begin
    wcnt_d = ((state_q == IDLE) || wdog_hit) ? '0 : wcnt_q + 1'b1;
    wdog_d = wdog_q | wdog_hit;
  end

  // Watchdog registers
  always_ff @(posedge clk) begin
    if (!rst) begin
      wcnt_q <= '0;
      wdog_q <= 1'b0;
    end else begin
      wcnt_q <= wcnt_d;
      wdog_q <= wdog_d;
    end
  end

  assign wdog_err = wdog_q;
`else
  assign wdog_hit = 1'b0;
  // WDOG_CYCLES only has meaning with the watchdog built; the term folds to 0
  assign wdog_err = 1'b0 && (WDOG_CYCLES != 0);
`endif

  assign frame_data = frame_q;
  assign tx_start   = txs_q;
  assign grant_id   = grant_q;
  assign arb_busy   = (state_q != IDLE);
  assign done_pulse = done_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter with a simple UartTx responder and a
// scoreboard of expected (grant, frame) pairs popped on each done_pulse.
module tb_uart_tx_arbiter;

  localparam int unsigned FT = 12;  // responder frame time in cycles

  typedef struct packed {
    logic [1:0] g;
    logic [9:0] f;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req_valid;
  logic [31:0] req_data;
  logic [3:0]  req_ready;
  logic [9:0]  frame_data;
  logic        tx_start;
  logic        tx_busy;
  logic        tx_done;
  logic [1:0]  grant_id;
  logic        arb_busy;
  logic        done_pulse;
  logic        wdog_err;

  logic [7:0]  bytes [4];
  bit          m_busy;
  int unsigned m_cnt;
  bit          done_r;
  bit          force_busy;
  bit          hold_done;

  exp_t        sb [$];
  logic [9:0]  sent_q [$];
  logic [1:0]  tb_rr;
  logic [1:0]  w;
  int unsigned cnt;
  int unsigned n_pass = 0;
  int unsigned n_fail = 0;

  assign req_data = {bytes[3], bytes[2], bytes[1], bytes[0]};
  assign tx_busy  = m_busy | force_busy;
  assign tx_done  = done_r;

  uart_tx_arbiter #(
    .NUM_REQ    (4),
    .DATA_BITS  (8),
    .FRAME_BITS (10),
    .WDOG_CYCLES(100)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready),
    .frame_data(frame_data),
    .tx_start  (tx_start),
    .tx_busy   (tx_busy),
    .tx_done   (tx_done),
    .grant_id  (grant_id),
    .arb_busy  (arb_busy),
    .done_pulse(done_pulse),
    .wdog_err  (wdog_err)
  );

  always #5 clk = ~clk;

  // UartTx stand-in: accepts tx_start when idle, stays busy FT cycles, pulses done
  always @(negedge clk) begin
    if (!rst) begin
      m_busy = 1'b0;
      m_cnt  = 0;
      done_r = 1'b0;
    end else begin
      done_r = 1'b0;
      if (m_busy) begin
        if (!hold_done) begin
          if (m_cnt == 0) begin
            m_busy = 1'b0;
            done_r = 1'b1;
          end else begin
            m_cnt--;
          end
        end
      end else if (tx_start && !force_busy) begin
        m_busy = 1'b1;
        m_cnt  = FT;
        sent_q.push_back(frame_data);
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL global_timeout: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [9:0] mkframe(input logic [7:0] d);
    return {1'b0, d[0], d[1], d[2], d[3], d[4], d[5], d[6], d[7], 1'b1};
  endfunction

  function automatic logic [1:0] model_winner(input logic [3:0] v, input logic [1:0] rr);
    logic [3:0] rot;
    logic [1:0] off;
    rot = (v >> rr) | (v << (4 - rr));
    if (rot[0])      off = 2'd0;
    else if (rot[1]) off = 2'd1;
    else if (rot[2]) off = 2'd2;
    else             off = 2'd3;
    return rr + off;
  endfunction

  // Wait for an accept, check it against the model, push the expected frame
  task automatic do_accept(input bit keep, output logic [1:0] wo);
    int unsigned b = 0;
    logic        busy_s;
    exp_t        e;
    #1;
    while (req_ready == '0 && b < 200) begin
      @(negedge clk);
      #1;
      b++;
    end
    check("accept_seen", 32'(b < 200), 32'd1);
    wo = model_winner(req_valid, tb_rr);
    check("req_ready_onehot", 32'(req_ready), 32'(4'b0001 << wo));
    busy_s = tx_busy;
    e.g = wo;
    e.f = mkframe(bytes[wo]);
    sb.push_back(e);
    tb_rr = wo + 2'd1;
    @(posedge clk);
    #1;
    check("ready_low_after_accept", 32'(req_ready), 32'd0);
    check("tx_start_after_accept", 32'(tx_start), 32'(!busy_s));
    check("frame_latched", 32'(frame_data), 32'(e.f));
    check("grant_latched", 32'(grant_id), 32'(wo));
    check("arb_busy_after_accept", 32'(arb_busy), 32'd1);
    if (keep) bytes[wo] = 8'($urandom);
    else      req_valid[wo] = 1'b0;
  endtask

  // Wait for done_pulse and compare against the oldest scoreboard entry
  task automatic wait_done();
    int unsigned b = 0;
    exp_t        e;
    logic [9:0]  s;
    while (b < 300) begin
      @(negedge clk);
      b++;
      if (done_pulse) break;
    end
    check("done_seen", 32'(done_pulse), 32'd1);
    check("sb_has_entry", 32'(sb.size() > 0), 32'd1);
    if (done_pulse && sb.size() > 0) begin
      e = sb.pop_front();
      s = (sent_q.size() > 0) ? sent_q.pop_front() : 'x;
      check("done_grant_id", 32'(grant_id), 32'(e.g));
      check("done_frame_data", 32'(frame_data), 32'(e.f));
      check("tx_line_frame", 32'(s), 32'(e.f));
    end
  endtask

  initial begin
    rst        = 1'b0;
    req_valid  = '0;
    bytes      = '{default: '0};
    force_busy = 1'b0;
    hold_done  = 1'b0;
    tb_rr      = '0;

    // reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    req_valid = '1;
    #1;
    check("rst_req_ready", 32'(req_ready), 32'd0);
    check("rst_frame", 32'(frame_data), 32'h3FF);
    check("rst_tx_start", 32'(tx_start), 32'd0);
    check("rst_grant", 32'(grant_id), 32'd0);
    check("rst_arb_busy", 32'(arb_busy), 32'd0);
    check("rst_done", 32'(done_pulse), 32'd0);
    check("rst_wdog", 32'(wdog_err), 32'd0);
    req_valid = '0;
    rst = 1'b1;

    // single request, 0xA5
    @(negedge clk);
    bytes[0]  = 8'hA5;
    req_valid = 4'b0001;
    do_accept(1'b0, w);
    check("t1_frame_literal", 32'(frame_data), 32'(10'b0101001011));
    wait_done();

    // 1 and 3 together from rr_ptr=0
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst   = 1'b1;
    tb_rr = '0;
    bytes[1]  = 8'h3E;
    bytes[3]  = 8'hC1;
    req_valid = 4'b1010;
    do_accept(1'b0, w);
    check("t2_first", 32'(w), 32'd1);
    wait_done();
    do_accept(1'b0, w);
    check("t2_second", 32'(w), 32'd3);
    wait_done();

    // all four continuously for 8 frames
    for (int i = 0; i < 4; i++) bytes[i] = 8'($urandom);
    req_valid = 4'b1111;
    for (int f = 0; f < 8; f++) begin
      do_accept(1'b1, w);
      check("t3_order", 32'(w), 32'(f % 4));
      if (f == 7) req_valid = '0;
      wait_done();
    end

    // UartTx still busy on entry to START
    @(negedge clk);
    force_busy = 1'b1;
    bytes[2]   = 8'h3C;
    req_valid  = 4'b0100;
    do_accept(1'b0, w);
    cnt = 0;
    repeat (50) begin
      @(negedge clk);
      if (tx_start) cnt++;
    end
    check("t4_start_held_low", cnt, 32'd0);
    check("t4_arb_busy", 32'(arb_busy), 32'd1);
    force_busy = 1'b0;
    @(negedge clk);
    #1;
    check("t4_start_rise", 32'(tx_start), 32'd1);
    check("t4_busy_rise", 32'(tx_busy), 32'd1);
    @(negedge clk);
    #1;
    check("t4_start_drop", 32'(tx_start), 32'd0);
    wait_done();

    // reset in the middle of WAIT_DONE
    @(negedge clk);
    bytes[1]  = 8'h77;
    req_valid = 4'b0010;
    do_accept(1'b0, w);
    repeat (4) @(negedge clk);
    #1;
    check("t5_in_wait_busy", 32'(arb_busy), 32'd1);
    check("t5_in_wait_start", 32'(tx_start), 32'd0);
    rst       = 1'b0;
    req_valid = '1;
    repeat (2) @(posedge clk);
    #1;
    check("t5_tx_start", 32'(tx_start), 32'd0);
    check("t5_arb_busy", 32'(arb_busy), 32'd0);
    check("t5_frame", 32'(frame_data), 32'h3FF);
    check("t5_req_ready", 32'(req_ready), 32'd0);
    @(negedge clk);
    req_valid = '0;
    sb.delete();
    sent_q.delete();
    tb_rr = '0;
    rst   = 1'b1;
    cnt   = 0;
    repeat (30) begin
      @(negedge clk);
      if (done_pulse) cnt++;
    end
    check("t5_no_done", cnt, 32'd0);

`ifdef UART_ARB_WDOG_EN
    // tx_done withheld: watchdog fires 100 edges after START entry
    hold_done = 1'b1;
    bytes[0]  = 8'h5A;
    req_valid = 4'b0001;
    do_accept(1'b0, w);
    repeat (99) @(posedge clk);
    #1;
    check("t6_wdog_before", 32'(wdog_err), 32'd0);
    check("t6_busy_before", 32'(arb_busy), 32'd1);
    @(posedge clk);
    #1;
    check("t6_wdog_fire", 32'(wdog_err), 32'd1);
    check("t6_idle", 32'(arb_busy), 32'd0);
    check("t6_tx_start", 32'(tx_start), 32'd0);
    check("t6_no_done", 32'(done_pulse), 32'd0);
    sb.delete();
    sent_q.delete();
    hold_done = 1'b0;
    cnt = 0;
    repeat (30) begin
      @(negedge clk);
      if (done_pulse) cnt++;
    end
    check("t6_late_done_ignored", cnt, 32'd0);
    bytes[1]  = 8'h81;
    req_valid = 4'b0010;
    do_accept(1'b0, w);
    wait_done();
    check("t6_wdog_sticky", 32'(wdog_err), 32'd1);
`else
    check("wdog_tied_low", 32'(wdog_err), 32'd0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_pass + n_fail);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
Shares one UartTx instance among NUM_REQ byte-producing requesters using round-robin arbitration. Each granted byte is wrapped into a 10-bit frame (start, 8 data, stop). The block sequences the UartTx tx_start/tx_busy/tx_done handshake and issues one frame at a time. It sits between client blocks (debug, status, loopback) and UartTx.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
DATA_BITS, 8, payload bits per requester; FRAME_BITS = DATA_BITS+2
FRAME_BITS, 10, width of frame_data to UartTx
WDOG_CYCLES, 1_000_000, watchdog limit in clk cycles (only with UART_ARB_WDOG_EN)

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-low (asserted when 0, sampled on rising clk)
req_valid  in  NUM_REQ  per-requester byte valid; held with data until ready
req_data  in  NUM_REQ*DATA_BITS  packed bytes; requester i uses [i*8+7:i*8]
req_ready  out  NUM_REQ  one-hot accept; transfer when valid&ready on a rising edge
frame_data  out  FRAME_BITS  frame to UartTx
tx_start  out  1  start request to UartTx
tx_busy  in  1  UartTx busy
tx_done  in  1  UartTx one-cycle done pulse
grant_id  out  clog2(NUM_REQ)  index of requester that owns the current frame
arb_busy  out  1  high whenever state != IDLE
done_pulse  out  1  one-cycle pulse on frame completion; grant_id is valid in that cycle
wdog_err  out  1  sticky watchdog error (only with UART_ARB_WDOG_EN; otherwise tied 0)

Behaviour:
- Reset (rst=0 at an edge) forces all registered outputs and state to known values:
  - state=IDLE, rr_ptr=0, frame_data=10'b1111111111, tx_start=0, grant_id=0.
  - arb_busy=0, done_pulse=0, wdog_err=0.
  - req_ready=0 (combinational; forced 0 while rst=0).
- Frame format: frame_data[9]=0 (start), frame_data[8:1]={data[0],...,data[7]} (frame_data[8]=data[0]), frame_data[0]=1 (stop). UartTx shifts frame_data[9] first, so data goes LSB-first.
- FSM states: IDLE -> START -> WAIT_DONE -> IDLE.
- IDLE:
  - Winner = first i with req_valid[i], searching from rr_ptr upward and wrapping modulo NUM_REQ.
  - req_ready[winner]=1 combinationally in the same cycle; all other req_ready bits are 0.
  - On that edge: latch the frame, grant_id<=winner, rr_ptr<=(winner+1)%NUM_REQ, state<=START.
  - If no req_valid is high, all outputs hold and no pointer moves.
- START:
  - tx_start=1 held high until tx_busy=1 is sampled; then tx_start<=0 and state<=WAIT_DONE.
  - If tx_busy is already 1 on entry (UartTx still finishing a prior frame), stay in START with tx_start low. Raise tx_start only once tx_busy=0 has been seen, then wait for tx_busy to rise.
- WAIT_DONE:
  - On tx_done=1: done_pulse=1 for one cycle, state<=IDLE.
  - tx_done arriving in the same cycle tx_busy rises in START is also accepted.
- frame_data is stable from the latch edge until the next latch; it is never modified while arb_busy=1.
- req_ready is never asserted outside IDLE. Minimum spacing between accepts: 3 cycles plus UartTx frame time.
- Fairness: a continuously requesting requester waits at most NUM_REQ-1 frames.
- Reset mid-frame: FSM returns to IDLE, tx_start drops immediately, and the in-flight byte is dropped. UartTx shares rst and aborts the frame too.
- rr_ptr wraps from NUM_REQ-1 to 0.

Optional Feature:
- Macro: UART_ARB_WDOG_EN.
- Defined:
  - A cycle counter runs in START and WAIT_DONE and clears on entry to IDLE.
  - If it reaches WDOG_CYCLES, wdog_err<=1 (sticky until reset), tx_start<=0, state<=IDLE, and no done_pulse is issued.
- Undefined: no counter is built, wdog_err is tied 0, and the FSM waits indefinitely.

Test Plan:
1. Reset release, then req_valid[0] with data 0xA5 -> req_ready[0] pulses for 1 cycle; frame_data=10'b0_10100101_1; tx_start rises the next cycle; done_pulse with grant_id=0 follows tx_done.
2. req_valid=4'b1010 simultaneously, rr_ptr=0 -> grant order 1 then 3; the tx line carries requester 1's byte first.
3. All four valid continuously for 8 frames -> grant_id sequence 0,1,2,3,0,1,2,3; no requester is skipped.
4. tx_busy forced high for 50 cycles on entering START -> tx_start stays 0 until tx_busy falls, then asserts and drops one cycle after tx_busy rises again.
5. rst=0 held for 2 cycles in mid WAIT_DONE -> tx_start=0, arb_busy=0, frame_data=all-ones, and no done_pulse for the aborted frame.
6. With UART_ARB_WDOG_EN and WDOG_CYCLES=100, tx_done withheld -> wdog_err=1 at cycle 100 after the START entry edge; FSM returns to IDLE and accepts the next request.
